// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the programmable sequence detector.
// Used by seq_det_ctrl and seq_match_core.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int TO_W_DEF    = 16;
    localparam int LEN_W       = 5;

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and Mealy window compare.
// z is combinational from x/x_valid; the caller gates x_valid with the run state.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_valid,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               clear,
    input  logic               overlap,
    output logic               z
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-2:0] history;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               primed;

    // fill + 1 >= len is fill >= len-1 without underflow at len = 0
    always_comb begin
        window = {history, x};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        primed = ({1'b0, fill} + 6'd1) >= {1'b0, len};
        z      = x_valid && primed && (((window ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            history <= '0;
            fill    <= '0;
        end else if (x_valid) begin
            history <= window[MAX_LEN-2:0];
            if (z && !overlap) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable Mealy sequence-detection controller: config, arm, count, done/abort.
// Optional SEQ_DET_TIMEOUT_EN builds the inter-match timeout down-counter.
//
// state | meaning
// IDLE  | config writable, waiting for start
// RUN   | matcher armed, serial stream gated in, matches counted
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               x_valid,
    input  logic               x,
    output logic               z,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_cnt
);

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               len_ok;
    logic               start_clr;
    logic               err_set;
    logic               done_nxt;
    logic               to_nxt;
    logic               to_expire;
    logic               run_valid;

    assign busy      = (state == RUN);
    assign run_valid = busy && x_valid;
    assign len_ok    = (len_q != '0) && (int'(len_q) <= MAX_LEN);
    assign cnt_inc   = (&match_cnt) ? match_cnt : match_cnt + 1'b1;

    seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
        .clk     (clk),
        .rst     (rst),
        .x_valid (run_valid),
        .x       (x),
        .pattern (pattern_q),
        .len     (len_q),
        .clear   (start_clr),
        .overlap (overlap_q),
        .z       (z)
    );

`ifdef SEQ_DET_TIMEOUT_EN
    logic [TO_W-1:0] timeout_q;
    logic [TO_W-1:0] to_cnt;

    // Down-counter reloaded on start and on every match; expiry is the valid,
    // non-matching bit that would take it from 1 to 0.
    assign to_expire = run_valid && !z && (timeout_q != '0) && (to_cnt == TO_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= '0;
            to_cnt    <= '0;
        end else begin
            if (state == IDLE && cfg_we) begin
                timeout_q <= cfg_timeout;
            end
            if (start_clr) begin
                to_cnt <= timeout_q;
            end else if (run_valid) begin
                if (z) begin
                    to_cnt <= timeout_q;
                end else if (to_cnt != '0) begin
                    to_cnt <= to_cnt - 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^cfg_timeout;
    assign to_expire      = 1'b0;
`endif

    // Abort outranks completion and timeout; a match on the expiry bit wins.
    always_comb begin
        state_nxt = state;
        start_clr = 1'b0;
        err_set   = 1'b0;
        done_nxt  = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_nxt = RUN;
                        start_clr = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (z && (target_q != '0) && (cnt_inc == target_q)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (to_expire) begin
                    state_nxt = IDLE;
                    to_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cfg_err   <= 1'b0;
            match_cnt <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            timeout <= to_nxt;
            if (state == IDLE && cfg_we) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
            end
            if (err_set) begin
                cfg_err <= 1'b1;
            end else if (state == IDLE && cfg_we) begin
                cfg_err <= 1'b0;
            end
            if (start_clr) begin
                match_cnt <= '0;
            end else if (z) begin
                match_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl; inputs driven on the falling edge,
// outputs sampled 1 ns later. Timeout expectations follow SEQ_DET_TIMEOUT_EN.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [4:0]  cfg_len;
    logic        cfg_overlap;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_timeout;
    logic        start;
    logic        abort;
    logic        x_valid;
    logic        x;
    logic        z;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        cfg_err;
    logic [7:0]  match_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    seq_det_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .start       (start),
        .abort       (abort),
        .x_valid     (x_valid),
        .x           (x),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cfg_err     (cfg_err),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [4:0] len, input logic ovl,
                       input logic [7:0] tgt, input logic [15:0] tmo);
        @(negedge clk);
        x_valid     = 1'b0;
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_target  = tgt;
        cfg_timeout = tmo;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        x_valid = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        x_valid = 1'b0;
        abort   = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
    endtask

    task automatic send(input logic b, input logic ez, input string tag);
        @(negedge clk);
        x_valid = 1'b1;
        x       = b;
        #1;
        check(tag, z, ez);
    endtask

    task automatic gap(input string tag);
        @(negedge clk);
        x_valid = 1'b0;
        x       = 1'b1;
        #1;
        check(tag, z, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        x_valid = 1'b0;
        #1;
    endtask

    // stream bits 1..9, first bit at index 8
    logic [8:0] stream  = 9'b110101010;
    logic [8:0] z_ovl   = 9'b000010101;
    logic [8:0] z_novl  = 9'b000010001;

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; cfg_timeout = 0; start = 0; abort = 0; x_valid = 0; x = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tmo", timeout, 0);
        check("rst_err", cfg_err, 0);
        check("rst_cnt", match_cnt, 0);

        // 1: overlapping detection
        cfg(8'b1010, 4, 1, 0, 0);
        pulse_start();
        check("t1_busy_start", busy, 1);
        for (int i = 0; i < 9; i++) send(stream[8-i], z_ovl[8-i], "t1_z");
        settle();
        check("t1_cnt", match_cnt, 3);
        check("t1_busy", busy, 1);
        check("t1_done", done, 0);
        pulse_abort();
        check("t1_abort_busy", busy, 0);

        // 2: non-overlapping detection
        cfg(8'b1010, 4, 0, 0, 0);
        pulse_start();
        check("t2_cnt_clr", match_cnt, 0);
        for (int i = 0; i < 9; i++) send(stream[8-i], z_novl[8-i], "t2_z");
        settle();
        check("t2_cnt", match_cnt, 2);
        pulse_abort();

        // 3: target completion after the second match
        cfg(8'b1010, 4, 1, 2, 0);
        pulse_start();
        for (int i = 0; i < 7; i++) send(stream[8-i], z_ovl[8-i], "t3_z");
        settle();
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_cnt", match_cnt, 2);
        send(stream[1], 0, "t3_z8");
        check("t3_done_once", done, 0);
        send(stream[0], 0, "t3_z9");
        settle();
        check("t3_cnt_hold", match_cnt, 2);

        // 4: gaps inside a window, config and start ignored while running
        cfg(8'b1010, 4, 1, 0, 0);
        pulse_start();
        send(1, 0, "t4_z");
        gap("t4_gap");
        send(0, 0, "t4_z");
        gap("t4_gap");
        gap("t4_gap");
        send(1, 0, "t4_z");
        gap("t4_gap");
        send(0, 1, "t4_z_gapmatch");
        cfg(8'b1111, 4, 0, 1, 0);
        send(1, 0, "t4_z");
        send(0, 1, "t4_z_cfg_ignored");
        pulse_start();
        check("t4_start_ignored_cnt", match_cnt, 2);
        check("t4_busy", busy, 1);
        pulse_abort();
        check("t4_done", done, 0);

        // length-1 pattern
        cfg(8'b1, 1, 0, 0, 0);
        pulse_start();
        send(1, 1, "len1_z");
        send(0, 0, "len1_z");
        send(1, 1, "len1_z");
        settle();
        check("len1_cnt", match_cnt, 2);
        pulse_abort();

        // 5a: abort coincident with the target-reaching match
        cfg(8'b1010, 4, 1, 2, 0);
        pulse_start();
        send(1, 0, "t5_z");
        send(0, 0, "t5_z");
        send(1, 0, "t5_z");
        send(0, 1, "t5_z");
        send(1, 0, "t5_z");
        @(negedge clk);
        x_valid = 1'b1; x = 1'b0; abort = 1'b1;
        #1;
        check("t5_z_abort", z, 1);
        @(negedge clk);
        x_valid = 1'b0; abort = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_cnt", match_cnt, 2);
        pulse_abort();
        check("t5_idle_abort", busy, 0);

        // 5b: reset mid-run clears everything, including config
        cfg(8'b1010, 4, 1, 0, 0);
        pulse_start();
        send(1, 0, "t5b_z");
        send(0, 0, "t5b_z");
        send(1, 0, "t5b_z");
        send(0, 1, "t5b_z");
        @(negedge clk);
        x_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5b_busy", busy, 0);
        check("t5b_cnt", match_cnt, 0);
        check("t5b_done", done, 0);
        check("t5b_err", cfg_err, 0);
        pulse_start();
        check("t5b_cfg_cleared_err", cfg_err, 1);
        check("t5b_cfg_cleared_busy", busy, 0);

        // 5c: illegal lengths
        cfg(8'b1010, 0, 1, 0, 0);
        #1;
        check("t5c_err_cleared", cfg_err, 0);
        pulse_start();
        check("t5c_len0_err", cfg_err, 1);
        check("t5c_len0_busy", busy, 0);
        cfg(8'b1010, 9, 1, 0, 0);
        pulse_start();
        check("t5c_len9_err", cfg_err, 1);
        check("t5c_len9_busy", busy, 0);
        cfg(8'b1010, 8, 1, 0, 0);
        pulse_start();
        check("t5c_len8_err", cfg_err, 0);
        check("t5c_len8_busy", busy, 1);
        pulse_abort();

        // 6: timeout after six non-matching valid bits
        cfg(8'b1010, 4, 1, 0, 6);
        pulse_start();
        for (int i = 0; i < 6; i++) send(1, 0, "t6_z");
        settle();
`ifdef SEQ_DET_TIMEOUT_EN
        check("t6_timeout", timeout, 1);
        check("t6_busy", busy, 0);
        settle();
        check("t6_timeout_pulse", timeout, 0);
`else
        check("t6_timeout", timeout, 0);
        check("t6_busy", busy, 1);
        pulse_abort();
        check("t6_timeout_idle", timeout, 0);
`endif
        check("t6_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
